// File: rtl/hazard_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_sched_ctrl
//  Purpose  : Pipeline sequencer for the 5-stage core. Generates PC/latch
//             enables, bubble/flush controls, EX operand forward selects,
//             the halt drain sequence and saturating stall/flush counters.
//  Revision : 1.0  initial release
// ============================================================================
//  Encodings used on the shared-type ports:
//    Forward_t : RDAT_DS=0  ALUOUT_DS=1  DATA_DS=2  LUI_DS=3
//    PCSrc_t   : ADD4=0     BRANCH=1     JUMP=2     JR=3
//    W_mux_t   : ALUOUT=0   DATA=1       LUI=2      R31=3
// ============================================================================
module hazard_sched_ctrl #(
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwr,
  input  logic [1:0]       mem_wsel,
  input  logic [1:0]       mem_pcsrc,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwr,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             halt_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RDAT_DS    = 2'd0;
  localparam logic [1:0] ALUOUT_DS  = 2'd1;
  localparam logic [1:0] DATA_DS    = 2'd2;
  localparam logic [1:0] LUI_DS     = 2'd3;
  localparam logic [1:0] ADD4_PC    = 2'd0;
  localparam logic [1:0] WSEL_ALU   = 2'd0;
  localparam logic [1:0] WSEL_LUI   = 2'd2;
  localparam logic [1:0] WSEL_R31   = 2'd3;

  // Drain counter is at least 3 bits and wide enough to hold DRAIN_CYC.
  localparam int DCW = ($clog2(DRAIN_CYC + 1) > 3) ? $clog2(DRAIN_CYC + 1) : 3;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DCW-1:0]     dcnt_q, dcnt_d;
  logic               halt_q, halt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic dwait, redir, lduse, imiss;

  // Operand source select: MEM-stage result beats WB; a MEM load match
  // falls through to WB because the load-use bubble already separated them.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] s,
    input logic [4:0] m_rd, input logic m_wr, input logic [1:0] m_wsel,
    input logic [4:0] w_rd, input logic w_wr
  );
    logic mem_hit;
    mem_hit = m_wr && (m_rd == s);
    if (s == 5'd0)                                             return RDAT_DS;
    else if (mem_hit && m_wsel == WSEL_LUI)                    return LUI_DS;
    else if (mem_hit && (m_wsel == WSEL_ALU || m_wsel == WSEL_R31)) return ALUOUT_DS;
    else if (w_wr && (w_rd == s))                              return DATA_DS;
    else                                                       return RDAT_DS;
  endfunction

  // Hazard event decode.
  always_comb begin
    dwait = (mem_dren | mem_dwen) & ~dhit;
    redir = (mem_pcsrc != ADD4_PC);
    lduse = ex_memread & (ex_rd != 5'd0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
    imiss = ~ihit;
  end

  // Enable/flush/forward outputs: reset dominates, then state, then event priority.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwdA = fwd_sel(ex_rs, mem_rd, mem_regwr, mem_wsel, wb_rd, wb_regwr);
    fwdB = fwd_sel(ex_rt, mem_rd, mem_regwr, mem_wsel, wb_rd, wb_regwr);
    if (RST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
      fwdA = RDAT_DS;
      fwdB = RDAT_DS;
    end else if (state_q != S_RUN) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
    end else if (dwait) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
    end else if (redir) begin
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
    end else if (lduse || imiss) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Next-state: halt sequencing FSM and saturating perf counters.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    halt_d      = halt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_RUN: begin
        if (!pc_en && !redir && stall_cnt_q != '1)
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (redir && flush_cnt_q != '1)
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (wb_halt && !dwait) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          state_d = S_HALTED;
          halt_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      S_HALTED: halt_d = 1'b1;
      default:  state_d = S_RUN;
    endcase
  end

  // Single state register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_RUN;
      dcnt_q      <= '0;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halt_out  = halt_q & ~RST;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_sched_ctrl
//  Purpose  : Self-checking bench for hazard_sched_ctrl: table of directed
//             single-cycle vectors plus hand sequences for reset, counters
//             and the halt drain.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_sched_ctrl;

  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic RST;
  logic ihit, dhit, mem_dren, mem_dwen;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic ex_memread, mem_regwr, wb_regwr, wb_halt;
  logic [1:0] mem_wsel, mem_pcsrc;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush;
  logic [1:0] fwdA, fwdB;
  logic halt_out;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  hazard_sched_ctrl #(.DRAIN_CYC(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
    .mem_wsel(mem_wsel), .mem_pcsrc(mem_pcsrc), .wb_rd(wb_rd),
    .wb_regwr(wb_regwr), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .fwdA(fwdA), .fwdB(fwdB), .halt_out(halt_out),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    string      name;
    logic       ihit, dhit, dren, dwen, ex_memread, mem_regwr, wb_regwr;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic [1:0] mem_wsel, mem_pcsrc;
    logic [4:0] e_en;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0] e_fl;   // {ifid, idex, exmem}
    logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t base(input string nm);
    vec_t v;
    v.name = nm;
    v.ihit = 1; v.dhit = 1; v.dren = 0; v.dwen = 0;
    v.ex_memread = 0; v.mem_regwr = 0; v.wb_regwr = 0;
    v.id_rs = 1; v.id_rt = 2; v.ex_rs = 3; v.ex_rt = 4; v.ex_rd = 5;
    v.mem_rd = 6; v.wb_rd = 7; v.mem_wsel = 0; v.mem_pcsrc = 0;
    v.e_en = 5'b11111; v.e_fl = 3'b000; v.e_fa = 0; v.e_fb = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ihit = v.ihit; dhit = v.dhit; mem_dren = v.dren; mem_dwen = v.dwen;
    ex_memread = v.ex_memread; mem_regwr = v.mem_regwr; wb_regwr = v.wb_regwr;
    id_rs = v.id_rs; id_rt = v.id_rt; ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    ex_rd = v.ex_rd; mem_rd = v.mem_rd; wb_rd = v.wb_rd;
    mem_wsel = v.mem_wsel; mem_pcsrc = v.mem_pcsrc;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  endfunction

  function automatic logic [2:0] fl_vec();
    return {ifid_flush, idex_flush, exmem_flush};
  endfunction

  task automatic next_cyc();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    next_cyc();
    RST = 1'b0;
  endtask

  initial begin
    vec_t v;
    RST = 1'b1; wb_halt = 1'b0;
    drive(base("init"));

    // ---------------- vector table ----------------
    tbl.push_back(base("idle"));
    v = base("lduse_rs"); v.ex_memread = 1; v.ex_rd = 8; v.id_rs = 8;
    v.e_en = 5'b00111; v.e_fl = 3'b010; tbl.push_back(v);
    v = base("lduse_rd0"); v.ex_memread = 1; v.ex_rd = 0; v.id_rs = 0; tbl.push_back(v);
    v = base("lduse_rt"); v.ex_memread = 1; v.ex_rd = 12; v.id_rt = 12;
    v.e_en = 5'b00111; v.e_fl = 3'b010; tbl.push_back(v);
    v = base("fwd_mem_alu"); v.mem_rd = 9; v.wb_rd = 9; v.mem_regwr = 1; v.wb_regwr = 1;
    v.ex_rs = 9; v.mem_wsel = 0; v.e_fa = 1; tbl.push_back(v);
    v = base("fwd_wb"); v.mem_rd = 9; v.wb_rd = 9; v.mem_regwr = 0; v.wb_regwr = 1;
    v.ex_rs = 9; v.e_fa = 2; tbl.push_back(v);
    v = base("fwd_lui"); v.mem_rd = 9; v.wb_rd = 9; v.mem_regwr = 1; v.wb_regwr = 1;
    v.ex_rs = 9; v.mem_wsel = 2; v.e_fa = 3; tbl.push_back(v);
    v = base("fwd_memdata_to_wb"); v.mem_rd = 9; v.wb_rd = 9; v.mem_regwr = 1; v.wb_regwr = 1;
    v.ex_rs = 9; v.ex_rt = 9; v.mem_wsel = 1; v.e_fa = 2; v.e_fb = 2; tbl.push_back(v);
    v = base("fwd_r31_b"); v.mem_rd = 9; v.mem_regwr = 1; v.ex_rt = 9; v.mem_wsel = 3;
    v.e_fb = 1; tbl.push_back(v);
    v = base("fwd_r0"); v.ex_rs = 0; v.mem_rd = 0; v.mem_regwr = 1; v.wb_rd = 0;
    v.wb_regwr = 1; tbl.push_back(v);
    v = base("fwd_memdata_nowb"); v.mem_rd = 4; v.mem_regwr = 1; v.mem_wsel = 1;
    tbl.push_back(v);
    v = base("redir_imiss"); v.mem_pcsrc = 1; v.ihit = 0; v.e_fl = 3'b111; tbl.push_back(v);
    v = base("imiss"); v.ihit = 0; v.e_en = 5'b00111; v.e_fl = 3'b010; tbl.push_back(v);
    v = base("dwait_all"); v.dren = 1; v.dhit = 0; v.ex_memread = 1; v.ex_rd = 8; v.id_rs = 8;
    v.mem_pcsrc = 1; v.e_en = 5'b00000; tbl.push_back(v);
    v = base("dwait_store"); v.dwen = 1; v.dhit = 0; v.e_en = 5'b00000; tbl.push_back(v);
    v = base("dhit_redir"); v.dren = 1; v.dhit = 1; v.mem_pcsrc = 3; v.ex_memread = 1;
    v.ex_rd = 8; v.id_rs = 8; v.e_fl = 3'b111; tbl.push_back(v);
    v = base("lduse_imiss"); v.ihit = 0; v.ex_memread = 1; v.ex_rd = 8; v.id_rt = 8;
    v.e_en = 5'b00111; v.e_fl = 3'b010; tbl.push_back(v);

    // ---------------- reset state ----------------
    ex_rs = 9; mem_rd = 9; mem_regwr = 1; mem_wsel = 0;
    #1;
    chk("rst_en", en_vec(), 5'b00000);
    chk("rst_flush", fl_vec(), 3'b111);
    chk("rst_fwdA", fwdA, 2'd0);
    chk("rst_halt", halt_out, 1'b0);
    next_cyc();
    next_cyc();
    RST = 1'b0;
    drive(base("idle"));
    #1;
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      chk({tbl[i].name, "_en"}, en_vec(), tbl[i].e_en);
      chk({tbl[i].name, "_flush"}, fl_vec(), tbl[i].e_fl);
      chk({tbl[i].name, "_fwdA"}, fwdA, tbl[i].e_fa);
      chk({tbl[i].name, "_fwdB"}, fwdB, tbl[i].e_fb);
      next_cyc();
    end

    // ---------------- counters ----------------
    drive(base("idle"));
    do_reset();
    v = base("redir"); v.mem_pcsrc = 1; v.ihit = 0; drive(v);
    next_cyc();
    drive(base("idle"));
    #1;
    chk("cnt_flush_after_redir", flush_cnt, 1);
    chk("cnt_stall_after_redir", stall_cnt, 0);
    v = base("imiss"); v.ihit = 0; drive(v);
    for (int i = 0; i < 3; i++) next_cyc();
    #1;
    chk("cnt_stall_3", stall_cnt, 3);
    for (int i = 0; i < 20; i++) next_cyc();
    #1;
    chk("cnt_stall_sat", stall_cnt, 15);
    chk("cnt_flush_hold", flush_cnt, 1);

    // ---------------- halt blocked by dwait ----------------
    drive(base("idle"));
    do_reset();
    v = base("dw"); v.dren = 1; v.dhit = 0; drive(v);
    wb_halt = 1'b1;
    next_cyc();
    wb_halt = 1'b0;
    drive(base("idle"));
    #1;
    chk("halt_blocked_by_dwait_en", en_vec(), 5'b11111);

    // ---------------- halt drain ----------------
    do_reset();
    wb_halt = 1'b1;
    next_cyc();
    wb_halt = 1'b0;
    v = base("imiss"); v.ihit = 0; v.mem_pcsrc = 1; drive(v);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain%0d_en", i), en_vec(), 5'b00000);
      chk($sformatf("drain%0d_flush", i), fl_vec(), 3'b000);
      chk($sformatf("drain%0d_halt", i), halt_out, 1'b0);
      next_cyc();
    end
    #1;
    chk("halted_halt", halt_out, 1'b1);
    chk("halted_en", en_vec(), 5'b00000);
    for (int i = 0; i < 3; i++) next_cyc();
    #1;
    chk("halted_sticky", halt_out, 1'b1);
    chk("halted_stall_frozen", stall_cnt, 0);
    chk("halted_flush_frozen", flush_cnt, 0);

    // ---------------- reset out of HALTED ----------------
    RST = 1'b1;
    #1;
    chk("rst_halted_halt", halt_out, 1'b0);
    next_cyc();
    RST = 1'b0;
    drive(base("idle"));
    #1;
    chk("post_halt_en", en_vec(), 5'b11111);
    chk("post_halt_halt", halt_out, 1'b0);
    chk("post_halt_stall", stall_cnt, 0);

    // ---------------- reset mid-DRAIN ----------------
    wb_halt = 1'b1;
    next_cyc();
    wb_halt = 1'b0;
    next_cyc();
    do_reset();
    #1;
    chk("post_drain_rst_en", en_vec(), 5'b11111);
    for (int i = 0; i < 6; i++) next_cyc();
    #1;
    chk("post_drain_rst_nohalt", halt_out, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
